// File: rtl/fast_cmd_pkg.sv
// Shared fast-command symbol codes and sizing helpers for the fast-command link.
package fast_cmd_pkg;

    localparam int         FC_SYM_W      = 8;
    localparam logic [7:0] FC_IDLE       = 8'hF0;
    localparam logic [7:0] FC_LINK_RESET = 8'h33;
    localparam logic [7:0] FC_BCR        = 8'h5A;
    localparam logic [7:0] FC_QINJ       = 8'h69;
    localparam logic [7:0] FC_L1A        = 8'h96;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int fc_cnt_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/fast_cmd_fifo.sv
// Command queue for the fast-command transmitter: DEPTH x 8 synchronous FIFO
// with registered head, full and empty flags.
module fast_cmd_fifo
    import fast_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [7:0]                 push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [7:0]                 head
);

    localparam int AW = fc_cnt_w(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [7:0]    head_q, head_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          push_ok_s, pop_ok_s;

    assign push_ok_s = push && !full_q;
    assign pop_ok_s  = pop && !empty_q;

    // Next-state of storage, pointers, occupancy and the head that follows them.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok_s) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_ok_s) begin
            rd_d = rd_q + AW'(1);
        end else begin
            rd_d = rd_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + LW'(1);
            2'b01:   cnt_d = cnt_q - LW'(1);
            default: cnt_d = cnt_q;
        endcase
        // Reading from mem_d lets a push into an empty slot become the head directly.
        head_d  = mem_d[rd_d];
        full_d  = (cnt_d == LVL_FULL);
        empty_d = (cnt_d == {LW{1'b0}});
    end

    // Queue state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: 8'h00};
            wr_q    <= {AW{1'b0}};
            rd_q    <= {AW{1'b0}};
            cnt_q   <= {LW{1'b0}};
            head_q  <= 8'h00;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign level = cnt_q;
    assign head  = head_q;

endmodule

// File: rtl/fast_cmd_tx.sv
// Fast-command transmitter: queues 8-bit symbols and serialises them MSB-first,
// IDLE when empty. Optional periodic BCR insertion with macro FC_TX_AUTO_BCR_EN.
module fast_cmd_tx
    import fast_cmd_pkg::*;
#(
    parameter int CLK_PER_BIT = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int ORBIT_LEN   = 3564
) (
    input  logic                            clk1280,
    input  logic                            rst,
    input  logic                            cmd_valid,
    input  logic [7:0]                      cmd_code,
    output logic                            cmd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            fc_serial_out,
    output logic                            sym_start
);

    localparam int PW = fc_cnt_w(CLK_PER_BIT);
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_PER_BIT - 1);

    if (CLK_PER_BIT < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        ORBIT_LEN < 1 || ORBIT_LEN > 4096) begin : g_bad_cfg
        $error("fast_cmd_tx: illegal parameter set");
    end

    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          sym_start_q, sym_start_d;
    logic          boundary_s, bcr_slot_s, push_s, pop_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [7:0]    fifo_head_s;

    assign boundary_s = (bit_q == 3'd7) && (phase_q == PH_LAST);
    assign push_s     = cmd_valid && !fifo_full_s;
    assign pop_s      = boundary_s && !fifo_empty_s && !bcr_slot_s;

    fast_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk1280),
        .rst       (rst),
        .push      (push_s),
        .push_data (cmd_code),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (fifo_level),
        .head      (fifo_head_s)
    );

`ifdef FC_TX_AUTO_BCR_EN
    localparam logic [11:0] ORBIT_LAST = 12'(ORBIT_LEN - 1);
    logic [11:0] orbit_q, orbit_d;

    // Orbit position advances once per symbol; the wrap slot carries BCR.
    always_comb begin
        orbit_d = orbit_q;
        if (boundary_s) begin
            orbit_d = (orbit_q == ORBIT_LAST) ? 12'd0 : orbit_q + 12'd1;
        end else begin
            orbit_d = orbit_q;
        end
    end

    // Orbit counter register.
    always_ff @(posedge clk1280 or posedge rst) begin
        if (rst) begin
            orbit_q <= 12'd0;
        end else begin
            orbit_q <= orbit_d;
        end
    end

    assign bcr_slot_s = boundary_s && (orbit_q == ORBIT_LAST);
`else
    assign bcr_slot_s = 1'b0;
`endif

    // Bit timing, symbol load mux and shifter.
    always_comb begin
        phase_d     = phase_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        sym_start_d = 1'b0;
        if (boundary_s) begin
            phase_d     = {PW{1'b0}};
            bit_d       = 3'd0;
            sym_start_d = 1'b1;
            if (bcr_slot_s) begin
                shift_d = FC_BCR;
            end else if (!fifo_empty_s) begin
                shift_d = fifo_head_s;
            end else begin
                shift_d = FC_IDLE;
            end
        end else if (phase_q == PH_LAST) begin
            phase_d = {PW{1'b0}};
            bit_d   = bit_q + 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
        end else begin
            phase_d = phase_q + PW'(1);
        end
    end

    // Serialiser state; shift_q[7] is the registered line output.
    always_ff @(posedge clk1280 or posedge rst) begin
        if (rst) begin
            phase_q     <= {PW{1'b0}};
            bit_q       <= 3'd0;
            shift_q     <= FC_IDLE;
            sym_start_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            sym_start_q <= sym_start_d;
        end
    end

    assign fc_serial_out = shift_q[7];
    assign sym_start     = sym_start_q;
    assign cmd_ready     = !fifo_full_s;

endmodule
